// File: rtl/au_result_fifo.sv
// Result stage behind the arithmetic unit: an in-order FIFO toward register-file
// writeback, plus a sticky divide-by-zero flag and a saturating error counter.
module au_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic [2:0]               in_opcode,
    input  logic [4:0]               in_dest,
    input  logic                     in_b_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [2:0]               out_opcode,
    output logic [4:0]               out_dest,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_sticky,
    output logic [CNT_W-1:0]         err_cnt,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [2:0] OP_DIV = 3'b011;

    logic [31:0]   mem_result [DEPTH];
    logic [2:0]    mem_opcode [DEPTH];
    logic [4:0]    mem_dest   [DEPTH];
    logic          mem_err    [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          push_err;

    // Handshake: a beat transfers on any rising edge where valid and ready are both
    // high; ready depends only on occupancy, never on the opposite side's valid/ready.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign push_err  = push & (in_opcode == OP_DIV) & in_b_zero;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= in_result;
            mem_opcode[wr_ptr] <= in_opcode;
            mem_dest[wr_ptr]   <= in_dest;
            mem_err[wr_ptr]    <= (in_opcode == OP_DIV) & in_b_zero;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A clear coinciding with an error push leaves exactly that one error recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (err_clr) begin
            err_sticky <= push_err;
            err_cnt    <= CNT_W'(push_err);
        end else if (push_err) begin
            err_sticky <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

    always_comb begin
        out_result = '0;
        out_opcode = '0;
        out_dest   = '0;
        out_err    = 1'b0;
        if (out_valid) begin
            out_result = mem_result[rd_ptr];
            out_opcode = mem_opcode[rd_ptr];
            out_dest   = mem_dest[rd_ptr];
            out_err    = mem_err[rd_ptr];
        end
    end

endmodule

// File: tb/tb_au_result_fifo.sv
// Bench for au_result_fifo: directed scenarios plus a randomized run against a queue model.
module tb_au_result_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [2:0]  in_opcode;
    logic [4:0]  in_dest;
    logic        in_b_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_opcode;
    logic [4:0]  out_dest;
    logic        out_err;
    logic [2:0]  count;
    logic        err_sticky;
    logic [7:0]  err_cnt;
    logic        err_clr;

    // Model entry layout: {err, dest[4:0], opcode[2:0], result[31:0]}
    logic [40:0] exp_q[$];
    int          exp_sticky;
    int          exp_cnt;
    int          checks;
    int          passed;

    always #5 clk = ~clk;

    au_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_opcode(in_opcode), .in_dest(in_dest), .in_b_zero(in_b_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode), .out_dest(out_dest), .out_err(out_err),
        .count(count), .err_sticky(err_sticky), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    // Advance one clock, updating the reference model from the inputs being presented.
    task automatic step();
        bit push, pop, e;
        push = in_valid && (exp_q.size() < DEPTH);
        pop  = out_ready && (exp_q.size() > 0);
        e    = (in_opcode == 3'b011) && in_b_zero;
        if (!rst_n) begin
            exp_q.delete();
            exp_sticky = 0;
            exp_cnt    = 0;
        end else begin
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back({e, in_dest, in_opcode, in_result});
            if (err_clr) begin
                exp_sticky = 0;
                exp_cnt    = 0;
            end
            if (push && e) begin
                exp_sticky = 1;
                if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] r, input logic [2:0] op,
                          input logic [4:0] d, input logic bz);
        in_valid  = v;
        in_result = r;
        in_opcode = op;
        in_dest   = d;
        in_b_zero = bz;
    endtask

    function automatic logic [54:0] model_vec();
        logic [40:0] h;
        h = (exp_q.size() != 0) ? exp_q[0] : '0;
        return {exp_q.size() != 0, exp_q.size() != DEPTH, h[31:0], h[34:32], h[39:35], h[40],
                3'(exp_q.size()), exp_sticky[0], 8'(exp_cnt)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        set_in(1'b1, 32'hdead_beef, 3'b011, 5'd3, 1'b1);
        step();
        step();
        rst_n = 1'b1; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
        checks++;
        if ({out_valid, in_ready, count, err_sticky, err_cnt} !== {1'b0, 1'b1, 3'd0, 1'b0, 8'd0})
            $display("FAIL reset_ctrl: got v=%b r=%b cnt=%0d st=%b ec=%0d need v=0 r=1 cnt=0 st=0 ec=0",
                     out_valid, in_ready, count, err_sticky, err_cnt);
        else passed++;
        checks++;
        if ({out_result, out_opcode, out_dest, out_err} !== '0)
            $display("FAIL reset_data: got res=%h op=%b dest=%0d err=%b need all 0",
                     out_result, out_opcode, out_dest, out_err);
        else passed++;
    endtask

    task automatic test_single();
        set_in(1'b1, 32'h0000_0007, 3'b000, 5'd5, 1'b0);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL no_flow_through: got out_valid=%b need 0", out_valid);
        else passed++;
        step();
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
        checks++;
        if ({out_valid, out_result, out_dest, out_err, count} !== {1'b1, 32'd7, 5'd5, 1'b0, 3'd1})
            $display("FAIL single_head: got v=%b res=%h dest=%0d err=%b cnt=%0d need v=1 res=7 dest=5 err=0 cnt=1",
                     out_valid, out_result, out_dest, out_err, count);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, count, out_result} !== {1'b0, 3'd0, 32'd0})
            $display("FAIL single_drain: got v=%b cnt=%0d res=%h need v=0 cnt=0 res=0", out_valid, count, out_result);
        else passed++;
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 32'(i), 3'b001, 5'(i), 1'b0);
            step();
        end
        set_in(1'b1, 32'd5, 3'b001, 5'd5, 1'b0);
        checks++;
        if ({in_ready, count} !== {1'b0, 3'd4})
            $display("FAIL fill_full: got in_ready=%b cnt=%0d need in_ready=0 cnt=4", in_ready, count);
        else passed++;
        step();
        checks++;
        if ({count, out_result} !== {3'd4, 32'd1})
            $display("FAIL fill_reject: got cnt=%0d head=%0d need cnt=4 head=1", count, out_result);
        else passed++;
        // Push stays rejected even though a pop happens in the same full cycle.
        out_ready = 1'b1;
        step();
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
        checks++;
        if ({count, out_result} !== {3'd3, 32'd2})
            $display("FAIL fill_no_bypass: got cnt=%0d head=%0d need cnt=3 head=2", count, out_result);
        else passed++;
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (out_result !== 32'(i)) $display("FAIL fill_order: got %0d need %0d", out_result, i);
            else passed++;
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) $display("FAIL fill_empty: got cnt=%0d need 0", count);
        else passed++;
    endtask

    task automatic test_simul();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'(100 + i), 3'b010, 5'd7, 1'b0);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'(102 + i), 3'b010, 5'd7, 1'b0);
            checks++;
            if (out_result !== 32'(100 + i)) $display("FAIL simul_order: got %0d need %0d", out_result, 100 + i);
            else passed++;
            step();
            checks++;
            if (count !== 3'd2) $display("FAIL simul_count: got %0d need 2", count);
            else passed++;
        end
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_result !== 32'(110 + i)) $display("FAIL simul_tail: got %0d need %0d", out_result, 110 + i);
            else passed++;
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_div_zero();
        set_in(1'b1, 32'h8000_0000, 3'b011, 5'd1, 1'b1);
        step();
        set_in(1'b1, 32'h8000_0000, 3'b000, 5'd2, 1'b1);
        checks++;
        if ({out_err, out_opcode, err_sticky, err_cnt} !== {1'b1, 3'b011, 1'b1, 8'd1})
            $display("FAIL div_zero: got err=%b op=%b st=%b ec=%0d need err=1 op=011 st=1 ec=1",
                     out_err, out_opcode, err_sticky, err_cnt);
        else passed++;
        out_ready = 1'b1;
        step();
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
        checks++;
        if ({out_err, out_opcode, out_result, err_cnt} !== {1'b0, 3'b000, 32'h8000_0000, 8'd1})
            $display("FAIL not_div_zero: got err=%b op=%b res=%h ec=%0d need err=0 op=000 res=80000000 ec=1",
                     out_err, out_opcode, out_result, err_cnt);
        else passed++;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        set_in(1'b1, 32'h8000_0000, 3'b011, 5'd9, 1'b1);
        for (int i = 0; i < 300; i++) step();
        checks++;
        if ({err_cnt, err_sticky} !== {8'd255, 1'b1})
            $display("FAIL saturate: got ec=%0d st=%b need ec=255 st=1", err_cnt, err_sticky);
        else passed++;
        err_clr = 1'b1;
        step();
        checks++;
        if ({err_cnt, err_sticky} !== {8'd1, 1'b1})
            $display("FAIL clr_with_err: got ec=%0d st=%b need ec=1 st=1", err_cnt, err_sticky);
        else passed++;
        // Clear alone wipes the error state but keeps the queued entry.
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
        out_ready = 1'b0;
        step();
        err_clr = 1'b0;
        checks++;
        if ({err_cnt, err_sticky, count, out_valid} !== {8'd0, 1'b0, 3'd1, 1'b1})
            $display("FAIL clr_only: got ec=%0d st=%b cnt=%0d v=%b need ec=0 st=0 cnt=1 v=1",
                     err_cnt, err_sticky, count, out_valid);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(20 + i), 3'b011, 5'd4, 1'b1);
            step();
        end
        checks++;
        if ({count, out_valid} !== {3'd3, 1'b1})
            $display("FAIL mid_setup: got cnt=%0d v=%b need cnt=3 v=1", count, out_valid);
        else passed++;
        rst_n = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
        checks++;
        if ({out_valid, count, in_ready, err_sticky, err_cnt} !== {1'b0, 3'd0, 1'b1, 1'b0, 8'd0})
            $display("FAIL mid_reset: got v=%b cnt=%0d r=%b st=%b ec=%0d need v=0 cnt=0 r=1 st=0 ec=0",
                     out_valid, count, in_ready, err_sticky, err_cnt);
        else passed++;
        set_in(1'b1, 32'd9, 3'b000, 5'd0, 1'b0);
        step();
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
        checks++;
        if ({out_valid, out_result, count} !== {1'b1, 32'd9, 3'd1})
            $display("FAIL mid_fresh: got v=%b res=%0d cnt=%0d need v=1 res=9 cnt=1", out_valid, out_result, count);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [54:0] obs;
        logic [54:0] exp;
        int          errs;
        errs = 0;
        for (int i = 0; i < 500; i++) begin
            set_in(1'($urandom_range(0, 99) < 60), $urandom(),
                   ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 99) < 50);
            err_clr   = 1'($urandom_range(0, 99) < 3);
            obs = {out_valid, in_ready, out_result, out_opcode, out_dest, out_err,
                   count, err_sticky, err_cnt};
            exp = model_vec();
            checks++;
            if (obs !== exp) begin
                if (errs < 10) $display("FAIL random_cycle%0d: got %h need %h", i, obs, exp);
                errs++;
            end else passed++;
            step();
        end
        err_clr = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 3'b000, 5'd0, 1'b0);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        exp_sticky = 0;
        exp_cnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_div_zero();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/au_result_fifo.md
Name: au_result_fifo

Overview:
Downstream result stage for the combinational arithmetic unit. Each cycle it may capture the unit's 32-bit result with its opcode, destination tag and divide-by-zero qualifier into a small FIFO. It presents entries in order to the register-file writeback port over a valid/ready handshake. It also keeps a sticky divide-by-zero error flag and a saturating error counter for the status logic.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, minimum 2.
CNT_W, 8, width of the saturating divide-by-zero error counter.

Ports:
clk  input  1  rising-edge clock, sole clock domain.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
in_valid  input  1  producer has a result this cycle.
in_ready  output  1  FIFO can accept; equals not-full, with no combinational path from out_ready.
in_result  input  32  arithmetic unit output (outau).
in_opcode  input  3  opcode that produced in_result.
in_dest  input  5  destination register tag.
in_b_zero  input  1  operand b was zero for this operation.
out_valid  output  1  head entry is available.
out_ready  input  1  writeback consumes the head entry.
out_result  output  32  head entry result.
out_opcode  output  3  head entry opcode.
out_dest  output  5  head entry destination tag.
out_err  output  1  head entry is a divide-by-zero (stored opcode 3'b011 with b_zero=1).
count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
err_sticky  output  1  set by any accepted divide-by-zero entry; cleared only by err_clr or reset.
err_cnt  output  CNT_W  count of accepted divide-by-zero entries; saturates at all-ones.
err_clr  input  1  synchronous clear of err_sticky and err_cnt.

Behaviour:
- Handshake and pointers
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Storage is a circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits, wrapping from DEPTH-1 to 0. Occupancy is tracked by count.
  - Each entry stores result, opcode, dest and err. err = (in_opcode==3'b011) & in_b_zero, computed at push.
  - For opcodes other than 3'b011, in_b_zero is ignored. A result of 32'h80000000 alone never sets err.
- Latency and outputs
  - Push to an empty FIFO sets out_valid on the next cycle, so latency is 1.
  - out_* are driven from the head entry and hold stable while out_valid=1 and out_ready=0.
  - When out_valid=0, out_result, out_opcode, out_dest and out_err read 0.
- Occupancy
  - in_ready = (count != DEPTH). out_valid = (count != 0).
  - Full: in_ready=0 and a push is impossible, even if out_ready=1 in the same cycle. There is no bypass.
  - Empty: out_valid=0 and out_ready is ignored. There is no flow-through, so a push in the same cycle does not appear until the next cycle.
  - Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- Error tracking
  - On a push with err=1, err_sticky is set and err_cnt increments, saturating at 2^CNT_W-1.
  - err_clr and an err push in the same cycle: the result is err_sticky=1, err_cnt=1.
  - err_clr does not affect FIFO contents.
- Reset
  - rst_n=0 at a clock edge: pointers=0, count=0, out_valid=0, in_ready=1 from the next cycle, err_sticky=0, err_cnt=0, all out_* data=0.
  - Reset mid-operation discards all stored entries. in_valid and out_ready are ignored during reset.
  - Entry storage itself is not required to be cleared.

Test Plan:
- Reset, single push, drain: after rst_n low for 2 cycles, push result=32'h0000_0007, opcode=000, dest=5. Then out_valid=1 one cycle later with out_result=7, out_dest=5, out_err=0. Pop gives count=0.
- Fill and backpressure with DEPTH=4: push 4 entries (results 1, 2, 3, 4) with out_ready=0. Then in_ready=0 and count=4. A fifth in_valid with result 5 is not accepted. Pop all four; they come out in order 1, 2, 3, 4.
- Simultaneous push and pop at count=2 over 10 consecutive cycles: count stays 2, pointers wrap past 3 to 0, and the output order matches the input order.
- Divide-by-zero: push opcode=011, b_zero=1, result=32'h80000000. Required: out_err=1, err_sticky=1, err_cnt=1. Then push opcode=000, b_zero=1, result=32'h80000000. Required: out_err=0 and err_cnt stays 1.
- Saturation and clear with CNT_W=8: perform 300 error pushes (draining continuously). Required: err_cnt=255. Then assert err_clr in the same cycle as an error push. Required: err_cnt=1, err_sticky=1.
- Reset mid-operation: with 3 entries queued and out_valid=1, pull rst_n low for 1 cycle. Next cycle: out_valid=0, count=0, in_ready=1. A fresh push of result 9 appears as the first output.
